// File: rtl/fp_sort_buffer.sv
// Frame-based floating-point sorter: inserts each element in order into a
// DEPTH-entry array during LOAD, then streams the frame out head-first in DRAIN.

package fp_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } float;
endpackage

// One storage slot: holds an entry, compares the incoming element against it,
// and shifts up (insert) or down (pop) as directed by the top.
module fp_sort_slot
    import fp_pkg::*;
#(
    parameter bit DESCENDING  = 1'b1,
    parameter bit SIGNED_MODE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ins,
    input  logic pop,
    input  logic take,
    input  logic take_prev,
    input  float new_data,
    input  float prev_data,
    input  float next_data,
    output float data,
    output logic ahead
);
    logic mag_gt, mag_lt, gt, lt;

    // The implicit leading one is common to both sides, so {exp,frac} orders the same.
    assign mag_gt = {new_data.exp, new_data.frac} > {data.exp, data.frac};
    assign mag_lt = {new_data.exp, new_data.frac} < {data.exp, data.frac};

    always_comb begin
        gt = mag_gt;
        lt = mag_lt;
        if (SIGNED_MODE) begin
            if (new_data.sign != data.sign) begin
                gt = !new_data.sign;
                lt = new_data.sign;
            end else if (new_data.sign) begin
                gt = mag_lt;
                lt = mag_gt;
            end
        end
    end

    assign ahead = DESCENDING ? gt : lt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            data <= '0;
        else if (ins && take)
            data <= take_prev ? prev_data : new_data;
        else if (pop)
            data <= next_data;
    end
endmodule

module fp_sort_buffer
    import fp_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter bit DESCENDING  = 1'b1,
    parameter bit SIGNED_MODE = 1'b0,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  float          in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output float          out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [CW-1:0] count
);
    typedef enum logic {LOAD, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count_nxt;
    float             entry [DEPTH];
    logic [DEPTH-1:0] ahead, take;
    logic             acc, pop;

    assign in_ready = rst_n && (state == LOAD) && (count < CW'(DEPTH));
    assign acc      = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = entry[0];

    // take[j]: slot j changes on insert. Ahead bits are monotone over the
    // sorted occupied slots, so the first set bit is the insert point.
    for (genvar j = 0; j < DEPTH; j++) begin : g_slot
        assign take[j] = (count == CW'(j)) || ((CW'(j) < count) && ahead[j]);

        fp_sort_slot #(.DESCENDING(DESCENDING), .SIGNED_MODE(SIGNED_MODE)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .ins       (acc),
            .pop       (pop),
            .take      (take[j]),
            .take_prev ((j == 0) ? 1'b0 : take[(j == 0) ? 0 : j - 1]),
            .new_data  (in_data),
            .prev_data ((j == 0) ? float'('0) : entry[(j == 0) ? 0 : j - 1]),
            .next_data ((j == DEPTH - 1) ? float'('0) : entry[(j == DEPTH - 1) ? j : j + 1]),
            .data      (entry[j]),
            .ahead     (ahead[j])
        );
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count + CW'(acc) - CW'(pop);
        case (state)
            LOAD:    if (acc && (in_last || count == CW'(DEPTH - 1))) state_nxt = DRAIN;
            DRAIN:   if (pop && count == CW'(1)) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            count     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            out_valid <= (state_nxt == DRAIN);
            out_last  <= (state_nxt == DRAIN) && (count_nxt == CW'(1));
        end
    end
endmodule

// File: tb/tb_fp_sort_buffer.sv
// Randomized and directed checks of fp_sort_buffer in three configurations
// against a queue-based reference sorter.
module tb_fp_sort_buffer;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    float in_data = '0;
    logic in_vld = 1'b0, in_last = 1'b0, out_rdy = 1'b0;
    int   sel = 0;

    float od [3];
    logic ov [3], ol [3], ir [3];
    logic [3:0] c0, c1;
    logic [2:0] c2;

    int   total = 0, bad = 0;
    float mq [$];
    bit   rdy_pat [$];

    fp_sort_buffer #(.DEPTH(8), .DESCENDING(1'b1), .SIGNED_MODE(1'b0)) dut_mag (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_vld && sel == 0),
        .in_last(in_last), .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]),
        .out_last(ol[0]), .out_ready(out_rdy && sel == 0), .count(c0));

    fp_sort_buffer #(.DEPTH(8), .DESCENDING(1'b0), .SIGNED_MODE(1'b1)) dut_sgn (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_vld && sel == 1),
        .in_last(in_last), .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]),
        .out_last(ol[1]), .out_ready(out_rdy && sel == 1), .count(c1));

    fp_sort_buffer #(.DEPTH(4), .DESCENDING(1'b1), .SIGNED_MODE(1'b0)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_vld && sel == 2),
        .in_last(in_last), .in_ready(ir[2]), .out_data(od[2]), .out_valid(ov[2]),
        .out_last(ol[2]), .out_ready(out_rdy && sel == 2), .count(c2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d got=%0h want=%0h t=%0t", tag, sel, obs, exp, $time);
        end
    endtask

    function automatic int cnt();
        case (sel)
            0:       return int'(c0);
            1:       return int'(c1);
            default: return int'(c2);
        endcase
    endfunction

    function automatic int depth_of();
        return (sel == 2) ? 4 : 8;
    endfunction

    function automatic float mk(input bit s, input int e, input int f);
        float r;
        r.sign = s;
        r.exp  = 8'(e);
        r.frac = 23'(f);
        return r;
    endfunction

    // Map a value onto an integer line: magnitude, or signed with -0 just below +0.
    function automatic int key(input float f);
        int m;
        m = int'({f.exp, f.frac});
        if (sel == 1) return f.sign ? -m - 1 : m;
        return m;
    endfunction

    function automatic bit ahead_m(input float a, input float b);
        if (sel == 1) return key(a) < key(b);
        return key(a) > key(b);
    endfunction

    function automatic void model_ins(input float d);
        int p;
        p = mq.size();
        for (int i = 0; i < mq.size(); i++)
            if (ahead_m(d, mq[i])) begin
                p = i;
                break;
            end
        mq.insert(p, d);
    endfunction

    function automatic float rnd_float();
        int fr [4];
        fr[0] = 0; fr[1] = 'h100000; fr[2] = 'h200000; fr[3] = int'($urandom_range(0, 'h7fffff));
        return mk(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 4)),
                  fr[$urandom_range(0, 3)]);
    endfunction

    // Called at a negedge; returns at the negedge after the element is accepted.
    task automatic push(input float d, input bit last);
        int t;
        t = 0;
        in_data = d; in_last = last; in_vld = 1'b1;
        while (!ir[sel] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready", 64'(ir[sel]), 64'd1);
        if (ir[sel]) begin
            chk("count_load", 64'(cnt()), 64'(mq.size()));
            model_ins(d);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int npop, input bit keep);
        int t, popped;
        t = 0; popped = 0;
        if (!keep) begin
            in_vld = 1'b0; in_last = 1'b0;
        end
        while (popped < npop && mq.size() > 0 && t < 200) begin
            out_rdy = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : ($urandom_range(0, 9) < 7);
            chk("out_valid", 64'(ov[sel]), 64'd1);
            chk("in_ready_drain", 64'(ir[sel]), 64'd0);
            chk("out_data", 64'(od[sel]), 64'(mq[0]));
            chk("out_last", 64'(ol[sel]), 64'(mq.size() == 1));
            chk("count_drain", 64'(cnt()), 64'(mq.size()));
            if (out_rdy) begin
                void'(mq.pop_front());
                popped++;
            end
            t++;
            @(negedge clk);
        end
        out_rdy = 1'b0;
        chk("pops", 64'(popped), 64'(npop));
        if (mq.size() == 0) begin
            chk("turn_ready", 64'(ir[sel]), 64'd1);
            chk("turn_valid", 64'(ov[sel]), 64'd0);
            chk("turn_count", 64'(cnt()), 64'd0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            chk("rst_valid", 64'(ov[k]), 64'd0);
            chk("rst_last", 64'(ol[k]), 64'd0);
            chk("rst_data", 64'(od[k]), 64'd0);
            chk("rst_count", 64'(cnt()), 64'd0);
            chk("rst_ready", 64'(ir[k]), 64'd0);
        end
        rst_n = 1'b1;
        sel = 0;
        @(negedge clk);

        // magnitude descending
        push(mk(0, 3, 0), 0); push(mk(0, 7, 0), 0); push(mk(0, 1, 0), 0); push(mk(0, 5, 0), 1);
        chk("exp_head", 64'(od[0].exp), 64'd7);
        drain(4, 0);

        // fraction and sign tiebreak
        push(mk(0, 4, 'h200000), 0); push(mk(1, 4, 'h100000), 0); push(mk(1, 4, 'h200000), 1);
        drain(3, 0);

        // signed ascending
        sel = 1;
        push(mk(1, 128, 0), 0); push(mk(0, 127, 0), 0); push(mk(1, 126, 0), 0);
        push(mk(0, 0, 0), 0); push(mk(1, 0, 0), 1);
        chk("signed_head", 64'(od[1]), 64'(mk(1, 128, 0)));
        drain(5, 0);

        // implicit last at DEPTH=4, then carry on into the next frame
        sel = 2;
        push(mk(0, 2, 0), 0); push(mk(0, 9, 0), 0); push(mk(0, 4, 0), 0); push(mk(0, 6, 5), 0);
        chk("implicit_ready", 64'(ir[2]), 64'd0);
        in_data = mk(0, 8, 0);
        drain(4, 1);
        push(mk(0, 8, 0), 0); push(mk(1, 1, 3), 0); push(mk(0, 30, 0), 1);
        drain(3, 0);

        // backpressure
        sel = 0;
        push(mk(0, 10, 1), 0); push(mk(0, 12, 0), 0); push(mk(1, 11, 0), 1);
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        drain(3, 0);

        // reset after two of three pops
        push(mk(0, 1, 0), 0); push(mk(0, 2, 0), 0); push(mk(0, 3, 0), 1);
        rdy_pat = '{1'b1, 1'b1};
        drain(2, 0);
        rst_n = 1'b0;
        #1 chk("rst_mid_ready", 64'(ir[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        #1;
        chk("post_rst_count", 64'(cnt()), 64'd0);
        chk("post_rst_valid", 64'(ov[0]), 64'd0);
        chk("post_rst_ready", 64'(ir[0]), 64'd1);
        push(mk(0, 5, 0), 0); push(mk(0, 6, 0), 1);
        drain(2, 0);

        // random frames on every configuration
        for (int k = 0; k < 3; k++) begin
            sel = k;
            for (int f = 0; f < 6; f++) begin
                int n;
                bit use_last;
                n = int'($urandom_range(1, depth_of()));
                use_last = (n < depth_of()) || ($urandom_range(0, 1) == 1);
                for (int i = 0; i < n; i++) push(rnd_float(), use_last && (i == n - 1));
                drain(n, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/fp_sort_buffer.md
# fp_sort_buffer

Frame-based floating-point sorter: accepts a frame of up to DEPTH `float` values (fp package type: sign, exp, frac) on a valid/ready stream, keeps them ordered on every insert, then streams the frame out in sorted order. It generalises the single-pair big/small exponent-then-fraction compare to a parametrised depth, selectable sort direction and an optional sign-aware mode. It sits ahead of the FP adder/accumulator chain so operands reach it largest-first.

## Interface
- DEPTH, 8: maximum elements per frame; legal range 2..64.
- DESCENDING, 1: 1 = largest first, 0 = smallest first.
- SIGNED_MODE, 0: 0 = magnitude order (exp, then {1'b1,frac}; sign ignored); 1 = true signed order.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  float  element to insert.
- in_valid  input  1  in_data valid.
- in_last  input  1  marks the final element of a frame; qualified by in_valid.
- in_ready  output  1  block accepts an element this cycle.
- out_data  output  float  current head of the sorted frame.
- out_valid  output  1  out_data valid.
- out_last  output  1  out_data is the final element of the frame.
- out_ready  input  1  downstream accepts out_data.
- count  output  $clog2(DEPTH+1)  elements currently held.

## Operation
- Storage: DEPTH-entry register array `entry[0..DEPTH-1]`, always sorted; entry[0] is the head.
- Compare "a ahead of b":
  - Magnitude mode: a.exp > b.exp, or equal exps and {1'b1,a.frac} > {1'b1,b.frac}. Equal exp and frac is a tie.
  - Signed mode: positive is ahead of negative, and +0 is ahead of -0. With equal signs, positive values use the magnitude order and negative values use the reverse magnitude order.
  - DESCENDING=0 inverts the ahead relation. Ties are not inverted.
- States: LOAD, DRAIN.
- LOAD:
  - in_ready = (count < DEPTH).
  - On accept, the new element is inserted at the first position whose occupant it is strictly ahead of, else at index count. Later entries shift up by one. count increments.
  - Ties are stable: a new element goes behind existing equal elements.
  - Move to DRAIN when the accepted element has in_last=1, or when count reaches DEPTH (an implicit last).
- DRAIN:
  - in_ready=0, out_valid=1, out_data=entry[0], out_last=(count==1).
  - On out_valid && out_ready, entries shift down by one and count decrements.
  - On popping the element with out_last=1, count becomes 0 and the state returns to LOAD.
- The in_last value on an unaccepted beat is ignored.
- Sort keys are compared as bit fields only. NaN and Inf are ordered by their exp/frac bits with no special handling.

## Timing
- Reset (rst_n=0 at an edge): state=LOAD, count=0, all entries 0, out_valid=0, out_last=0, out_data=0.
- in_ready is 0 during any cycle in which rst_n is low.
- Insert: one element per cycle at full throughput, with a single-cycle combinational compare against all entries.
- Latency: the last element is accepted at edge t. out_valid=1 in the cycle after edge t, and out_data is already correctly sorted in that cycle.
- Drain: one element per cycle while out_ready=1. out_ready low holds out_data, out_valid and out_last stable.
- Turnaround: the final pop at edge t puts the block in LOAD with in_ready=1 in the cycle after edge t. There is no bubble beyond that cycle.
- Load and drain never overlap. in_ready and out_valid are never high in the same cycle.
- A full frame takes DEPTH load cycles plus DEPTH drain cycles minimum.
- Reset mid-frame, in either state, discards all held data and returns to the reset values at that edge. No partial output is produced.
- in_valid with in_ready=0 is not consumed. The source must hold in_data.

## Test plan
- Magnitude sort: DEPTH=8, DESCENDING=1, SIGNED_MODE=0. Load the 4 exps 3,7,1,5 (frac=0), with in_last on the 4th.
  - Required: out exps 7,5,3,1, out_last on 1, count 4→0, and in_ready=1 the cycle after the final pop.
- Fraction and sign tiebreak: load exp=4 frac=0x200000, exp=4 frac=0x100000 with sign=1, and exp=4 frac=0x200000 with sign=1, last on the 3rd.
  - Required in magnitude mode: frac 0x200000 (sign 0), then 0x200000 (sign 1, stable tie), then 0x100000.
- Signed mode, ascending: SIGNED_MODE=1, DESCENDING=0. Load -2.0, +1.0, -0.5, +0, -0, last on the 5th.
  - Required: -2.0, -0.5, -0, +0, +1.0.
- Implicit last: DEPTH=4. Send 6 elements with no in_last.
  - Required: in_ready drops after the 4th, and 4 sorted outputs appear with out_last on the 4th. Elements 5 and 6 are then accepted as the start of the next frame.
- Backpressure: a 3-element frame with out_ready toggling 1,0,0,1,1.
  - Required: out_data and out_last are held during the low cycles, exactly 3 pops occur, and there is no duplicate or lost element.
- Reset mid-operation: assert rst_n=0 for 1 cycle after 2 of 3 elements are drained.
  - Required: the next cycle shows count=0, out_valid=0 and in_ready=1, and a fresh 2-element frame sorts correctly.
